// File: rtl/lvds_clk_fwd_gen.sv
// Divide-by-N forwarded clock for an external DDR/LVDS output with exact 50% duty for any N >= 2.
// Outputs registered; en_ack rises two edges after en_req, stop always completes the current period.
module lvds_clk_fwd_gen #(
    parameter int DIV_W        = 8,
    parameter int TICK_PERIODS = 16368000,
    parameter int TICK_W       = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_req,
    input  logic [DIV_W-1:0] div_in,
    output logic             en_ack,
    output logic             d_rise,
    output logic             d_fall,
    output logic             period_tick,
    output logic             tick_toggle
);

    // S_ARM gives the one-cycle gap between sampling the request and the first half-bit.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0]  K_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]  K_TWO   = DIV_W'(2);
    localparam logic [TICK_W-1:0] PC_LAST = TICK_W'(TICK_PERIODS - 1);
    localparam logic [TICK_W-1:0] PC_ONE  = TICK_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_k;
    logic [DIV_W-1:0]   w_k_nxt;
    logic [DIV_W-1:0]   r_nl;
    logic [DIV_W-1:0]   w_nl_nxt;
    logic [DIV_W-1:0]   w_nl_req;
    logic               w_last;
    logic               w_active_nxt;
    logic               w_rise_nxt;
    logic               w_fall_nxt;
    logic               w_tick_nxt;
    logic               r_en_ack;
    logic               r_d_rise;
    logic               r_d_fall;
    logic               r_period_tick;
    logic               r_tick_toggle;
    logic [TICK_W-1:0]  r_pc;

    assign w_nl_req = (div_in < K_TWO) ? K_TWO : div_in;
    assign w_last   = (r_k == r_nl - K_ONE);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_nl_nxt    = r_nl;
        case (r_state)
            S_IDLE: begin
                w_k_nxt = '0;
                if (en_req) begin
                    w_state_nxt = S_ARM;
                    w_nl_nxt    = w_nl_req;
                end
            end
            S_ARM: begin
                w_k_nxt     = '0;
                w_state_nxt = en_req ? S_RUN : S_STOP;
            end
            S_RUN, S_STOP: begin
                if (w_last) begin
                    w_k_nxt     = '0;
                    w_nl_nxt    = w_nl_req;
                    w_state_nxt = en_req ? S_RUN : S_IDLE;
                end else begin
                    w_k_nxt     = r_k + K_ONE;
                    w_state_nxt = en_req ? S_RUN : S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    // Decode in DIV_W+1 bits so 2k and 2k+1 never overflow for large k.
    assign w_active_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_STOP);
    assign w_rise_nxt   = w_active_nxt && ({w_k_nxt, 1'b0} < {1'b0, w_nl_nxt});
    assign w_fall_nxt   = w_active_nxt && ({w_k_nxt, 1'b1} < {1'b0, w_nl_nxt});
    assign w_tick_nxt   = w_active_nxt && (w_k_nxt == w_nl_nxt - K_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_nl          <= K_TWO;
            r_en_ack      <= 1'b0;
            r_d_rise      <= 1'b0;
            r_d_fall      <= 1'b0;
            r_period_tick <= 1'b0;
            r_pc          <= '0;
            r_tick_toggle <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_k           <= w_k_nxt;
            r_nl          <= w_nl_nxt;
            r_en_ack      <= w_active_nxt;
            r_d_rise      <= w_rise_nxt;
            r_d_fall      <= w_fall_nxt;
            r_period_tick <= w_tick_nxt;
            // r_period_tick marks the cycle now ending as the last of its period.
            if (r_period_tick) begin
                if (r_pc == PC_LAST) begin
                    r_pc          <= '0;
                    r_tick_toggle <= ~r_tick_toggle;
                end else begin
                    r_pc <= r_pc + PC_ONE;
                end
            end
        end
    end

    assign en_ack      = r_en_ack;
    assign d_rise      = r_d_rise;
    assign d_fall      = r_d_fall;
    assign period_tick = r_period_tick;
    assign tick_toggle = r_tick_toggle;

endmodule

// File: tb/tb_lvds_clk_fwd_gen.sv
// Directed bench for lvds_clk_fwd_gen; expected half-bit patterns are hand-written per divisor.
module tb_lvds_clk_fwd_gen;

    logic       clk;
    logic       rst_n;
    logic       en_req;
    logic [7:0] div_in;
    logic       en_ack;
    logic       d_rise;
    logic       d_fall;
    logic       period_tick;
    logic       tick_toggle;

    int checks   = 0;
    int failures = 0;

    lvds_clk_fwd_gen #(
        .DIV_W(8),
        .TICK_PERIODS(3),
        .TICK_W(25)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en_req(en_req),
        .div_in(div_in),
        .en_ack(en_ack),
        .d_rise(d_rise),
        .d_fall(d_fall),
        .period_tick(period_tick),
        .tick_toggle(tick_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: drop the request and wait (bounded) for the generator to go idle.
    task automatic drain();
        en_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!en_ack) break;
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en_req = 1'b0;
        div_in = 8'd0;
        tick();
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick, tick_toggle} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_state: got %b expected 00000", {en_ack, d_rise, d_fall, period_tick, tick_toggle});
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick, tick_toggle} !== 5'b00000) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected 00000", {en_ack, d_rise, d_fall, period_tick, tick_toggle});
        end
    endtask

    task automatic test_div4();
        logic [7:0] pr;
        logic [7:0] pf;
        logic [3:0] exp_v;
        pr = 8'b0011;
        pf = 8'b0011;
        en_req = 1'b1;
        div_in = 8'd4;
        tick();
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick} !== 4'b0000) begin
            failures++;
            $display("FAIL start_latency_first_edge: got %b expected 0000", {en_ack, d_rise, d_fall, period_tick});
        end
        tick();
        for (int c = 0; c < 8; c++) begin
            exp_v = {1'b1, pr[c % 4], pf[c % 4], (c % 4) == 3};
            checks++;
            if ({en_ack, d_rise, d_fall, period_tick} !== exp_v) begin
                failures++;
                $display("FAIL div4_cycle%0d: got %b expected %b", c, {en_ack, d_rise, d_fall, period_tick}, exp_v);
            end
            tick();
        end
        drain();
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick} !== 4'b0000) begin
            failures++;
            $display("FAIL div4_drain: got %b expected 0000", {en_ack, d_rise, d_fall, period_tick});
        end
    endtask

    task automatic test_odd_clamp();
        int         dv[3];
        int         nn[3];
        logic [7:0] prt[3];
        logic [7:0] pft[3];
        logic [3:0] exp_v;
        int         k;
        dv  = '{3, 0, 1};
        nn  = '{3, 2, 2};
        prt = '{8'b011, 8'b01, 8'b01};
        pft = '{8'b001, 8'b01, 8'b01};
        for (int t = 0; t < 3; t++) begin
            en_req = 1'b1;
            div_in = 8'(dv[t]);
            tick();
            tick();
            for (int c = 0; c < 2 * nn[t]; c++) begin
                k = c % nn[t];
                exp_v = {1'b1, prt[t][k], pft[t][k], k == nn[t] - 1};
                checks++;
                if ({en_ack, d_rise, d_fall, period_tick} !== exp_v) begin
                    failures++;
                    $display("FAIL div%0d_cycle%0d: got %b expected %b", dv[t], c, {en_ack, d_rise, d_fall, period_tick}, exp_v);
                end
                tick();
            end
            drain();
            checks++;
            if (en_ack !== 1'b0) begin
                failures++;
                $display("FAIL div%0d_drain: en_ack got %b expected 0", dv[t], en_ack);
            end
        end
    endtask

    task automatic test_div_change();
        logic [7:0] pr;
        logic [3:0] exp_v;
        en_req = 1'b1;
        div_in = 8'd4;
        tick();
        tick();
        pr = 8'b0011;
        for (int c = 0; c < 4; c++) begin
            exp_v = {1'b1, pr[c], pr[c], c == 3};
            checks++;
            if ({en_ack, d_rise, d_fall, period_tick} !== exp_v) begin
                failures++;
                $display("FAIL divchg_old_cycle%0d: got %b expected %b", c, {en_ack, d_rise, d_fall, period_tick}, exp_v);
            end
            if (c == 1) div_in = 8'd6;
            tick();
        end
        pr = 8'b000111;
        for (int c = 0; c < 6; c++) begin
            exp_v = {1'b1, pr[c], pr[c], c == 5};
            checks++;
            if ({en_ack, d_rise, d_fall, period_tick} !== exp_v) begin
                failures++;
                $display("FAIL divchg_new_cycle%0d: got %b expected %b", c, {en_ack, d_rise, d_fall, period_tick}, exp_v);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_stop();
        logic [7:0] pr;
        logic [7:0] pf;
        logic [3:0] exp_v;
        pr = 8'b00111;
        pf = 8'b00011;
        // Drop request mid-period: period finishes, then idle.
        en_req = 1'b1;
        div_in = 8'd5;
        tick();
        tick();
        tick();
        for (int c = 1; c < 5; c++) begin
            exp_v = {1'b1, pr[c], pf[c], c == 4};
            checks++;
            if ({en_ack, d_rise, d_fall, period_tick} !== exp_v) begin
                failures++;
                $display("FAIL stop_cycle%0d: got %b expected %b", c, {en_ack, d_rise, d_fall, period_tick}, exp_v);
            end
            if (c == 1) en_req = 1'b0;
            tick();
        end
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick} !== 4'b0000) begin
            failures++;
            $display("FAIL stop_idle: got %b expected 0000", {en_ack, d_rise, d_fall, period_tick});
        end
        // Drop and re-raise before the boundary: waveform continues untouched.
        en_req = 1'b1;
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            exp_v = {1'b1, pr[c % 5], pf[c % 5], (c % 5) == 4};
            checks++;
            if ({en_ack, d_rise, d_fall, period_tick} !== exp_v) begin
                failures++;
                $display("FAIL reraise_cycle%0d: got %b expected %b", c, {en_ack, d_rise, d_fall, period_tick}, exp_v);
            end
            if (c == 1) en_req = 1'b0;
            if (c == 3) en_req = 1'b1;
            tick();
        end
        drain();
        // Request falls in the boundary cycle itself: that period is the last.
        en_req = 1'b1;
        div_in = 8'd4;
        tick();
        tick();
        tick();
        tick();
        tick();
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick} !== 4'b1001) begin
            failures++;
            $display("FAIL boundary_last_cycle: got %b expected 1001", {en_ack, d_rise, d_fall, period_tick});
        end
        en_req = 1'b0;
        tick();
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick} !== 4'b0000) begin
            failures++;
            $display("FAIL boundary_stop: got %b expected 0000", {en_ack, d_rise, d_fall, period_tick});
        end
    endtask

    task automatic test_pulse();
        logic [7:0] pr;
        logic [7:0] pf;
        logic [3:0] exp_v;
        pr = 8'b011;
        pf = 8'b001;
        en_req = 1'b1;
        div_in = 8'd3;
        tick();
        en_req = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            exp_v = {1'b1, pr[c], pf[c], c == 2};
            checks++;
            if ({en_ack, d_rise, d_fall, period_tick} !== exp_v) begin
                failures++;
                $display("FAIL pulse_cycle%0d: got %b expected %b", c, {en_ack, d_rise, d_fall, period_tick}, exp_v);
            end
            tick();
        end
        tick();
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick} !== 4'b0000) begin
            failures++;
            $display("FAIL pulse_idle: got %b expected 0000", {en_ack, d_rise, d_fall, period_tick});
        end
    endtask

    task automatic test_tick_toggle();
        logic [7:0] tg;
        logic [4:0] tg2;
        rst_n  = 1'b0;
        en_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        en_req = 1'b1;
        div_in = 8'd2;
        tick();
        tick();
        tg = 8'b11000000;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if ({tick_toggle, period_tick} !== {tg[c], (c % 2) == 1}) begin
                failures++;
                $display("FAIL toggle_cycle%0d: got %b expected %b", c, {tick_toggle, period_tick}, {tg[c], (c % 2) == 1});
            end
            if (c == 7) en_req = 1'b0;
            tick();
        end
        tick();
        tick();
        checks++;
        if ({en_ack, tick_toggle} !== 2'b01) begin
            failures++;
            $display("FAIL toggle_held_idle: got %b expected 01", {en_ack, tick_toggle});
        end
        en_req = 1'b1;
        tick();
        tick();
        tg2 = 5'b01111;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (tick_toggle !== tg2[c]) begin
                failures++;
                $display("FAIL toggle_resume_cycle%0d: got %b expected %b", c, tick_toggle, tg2[c]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_async_reset();
        logic [7:0] pr;
        logic [7:0] pf;
        logic [3:0] exp_v;
        pr = 8'b0001111;
        pf = 8'b0000111;
        en_req = 1'b1;
        div_in = 8'd7;
        tick();
        tick();
        tick();
        tick();
        tick();
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick} !== 4'b1100) begin
            failures++;
            $display("FAIL rst_pre_k3: got %b expected 1100", {en_ack, d_rise, d_fall, period_tick});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en_ack, d_rise, d_fall, period_tick, tick_toggle} !== 5'b00000) begin
            failures++;
            $display("FAIL rst_async: got %b expected 00000", {en_ack, d_rise, d_fall, period_tick, tick_toggle});
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (en_ack !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart_arm: en_ack got %b expected 0", en_ack);
        end
        tick();
        for (int c = 0; c < 7; c++) begin
            exp_v = {1'b1, pr[c], pf[c], c == 6};
            checks++;
            if ({en_ack, d_rise, d_fall, period_tick} !== exp_v) begin
                failures++;
                $display("FAIL rst_restart_cycle%0d: got %b expected %b", c, {en_ack, d_rise, d_fall, period_tick}, exp_v);
            end
            tick();
        end
        drain();
    endtask

    initial begin
        rst_n  = 1'b0;
        en_req = 1'b0;
        div_in = 8'd0;
        test_reset();
        test_div4();
        test_odd_clamp();
        test_div_change();
        test_stop();
        test_pulse();
        test_tick_toggle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lvds_clk_fwd_gen.md
# lvds_clk_fwd_gen

Generates a forwarded clock for an external LVDS clock output pair: an integer divide-by-N square wave with exact 50% duty for both even and odd N, built from the single system clock. It emits per-cycle rise and fall half-bits for an external DDR output register, which drives the differential output buffer. It provides a level-based enable handshake, glitch-free start and stop, and divisor changes only at period boundaries. It also drives a slow toggle output for a visible heartbeat LED.

## Interface
- DIV_W, 8: width of divisor input/latch.
- TICK_PERIODS, 16368000: output periods per `tick_toggle` inversion.
- TICK_W, 25: width of period counter; must satisfy 2^TICK_W > TICK_PERIODS.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_req  in  1  level request: 1 = run forwarded clock, 0 = stop.
- div_in  in  DIV_W  divisor N (output period = N clk cycles); values 0 and 1 clamp to 2.
- en_ack  out  1  1 while the generator is in RUN or STOP.
- d_rise  out  1  output level for first half of the current clk cycle (DDR D1).
- d_fall  out  1  output level for second half of the current clk cycle (DDR D2).
- period_tick  out  1  one-cycle pulse in the last cycle of each output period.
- tick_toggle  out  1  inverts once every TICK_PERIODS completed periods.

## Operation
- Phase counter k, width DIV_W, counts 0..Nl-1, where Nl is the latched divisor.
  - In the next clk cycle: k = (k == Nl-1) ? 0 : k+1.
- Half-bit decode, computed in DIV_W+1 bits:
  - d_rise = (2k < Nl).
  - d_fall = (2k+1 < Nl).
  - The high time is therefore exactly Nl of the 2·Nl half-cycles.
- States:
  - IDLE: k = 0; d_rise = d_fall = 0; en_ack = 0; period_tick = 0.
    - en_req = 1 → RUN. Latch Nl = max(div_in, 2). k = 0.
  - RUN: free-running k.
    - At k == Nl-1: period_tick = 1. Re-latch Nl = max(div_in, 2) for the next period.
    - en_req = 0 → STOP. k continues without a break.
  - STOP: same counting and decode as RUN.
    - en_req = 1 → RUN, with no phase disturbance.
    - At k == Nl-1 with en_req = 0: period_tick = 1, then → IDLE. The final period is always completed.
- div_in is sampled only on IDLE→RUN and at period boundaries. Changes mid-period have no effect until the next boundary.
- Period counter pc:
  - Increments at each period_tick.
  - When pc == TICK_PERIODS-1 at a period_tick: pc = 0 and tick_toggle inverts.
  - pc and tick_toggle hold their values in IDLE. They are not cleared on stop.
- All outputs are registers. They update at the same clk edge as the state and k they reflect.

## Timing
- Reset values: en_ack = 0, d_rise = 0, d_fall = 0, period_tick = 0, tick_toggle = 0, state IDLE, k = 0, pc = 0, Nl = 2.
- Reset asserted mid-period forces the reset values immediately, regardless of the clock.
- Start latency:
  - en_req is sampled high at edge t in IDLE.
  - After edge t+1: en_ack = 1 and the first output period begins with (d_rise, d_fall) = (1,1).
- Stop latency: en_ack falls at the edge after the period_tick of the final period. The outputs return to (0,0) at that same edge.
- period_tick is asserted during cycle k == Nl-1. It is never asserted in IDLE.
- A one-cycle en_req pulse in IDLE starts exactly one full period, then the block returns to IDLE.
- A one-cycle en_req low in RUN with k ≠ Nl-1 leaves the waveform unchanged, because it is back in RUN before the boundary.
- When en_req falls in the boundary cycle k == Nl-1 itself, that period is the last one.

## Test plan
- div_in = 4, en_req held high → en_ack rises 2 edges after the request. (d_rise, d_fall) repeats (1,1),(1,1),(0,0),(0,0). period_tick is high in every 4th cycle.
- div_in = 3 → pattern repeats (1,1),(1,0),(0,0), giving 3 of 6 half-cycles high. div_in = 0 and div_in = 1 → pattern (1,1),(0,0), identical to div_in = 2.
- Running with N = 4, set div_in = 6 at k = 1 → the current period completes as N = 4. The next period is (1,1)×3 followed by (0,0)×3.
- N = 5, drop en_req at k = 1 → the waveform continues through k = 4 with period_tick. The outputs are then (0,0) and en_ack = 0 one edge later. Repeat the test with en_req re-raised at k = 3 → no interruption and en_ack stays 1.
- TICK_PERIODS = 3, N = 2 → tick_toggle inverts every 6 cycles. Stop and restart the generator → tick_toggle is preserved and counting resumes from the held pc.
- Assert rst_n = 0 at N = 7, k = 3 → all outputs are 0 asynchronously. After release with en_req high, a fresh period starts at k = 0.
